// File: rtl/imem_loader_if.sv
// Loader-side bus: byte-stream input, instruction-memory write port and session status.
interface imem_loader_if #(parameter int ADDR_W = 10) ();
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Byte stream -> 32-bit imem words, 1 word/5 cycles, holds CPU until a clean load; s_ready low outside LEN/DATA.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match before DONE.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    imem_loader_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd7;
`endif

    // Comparison width wide enough for both the 16-bit length and the word index.
    localparam int              CW        = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [CW-1:0]   MAX_WORDS = {{(CW-1){1'b0}}, 1'b1} << ADDR_W;

    logic [2:0]       r_state;
    logic [15:0]      r_len;
    logic [1:0]       r_bcnt;
    logic [31:0]      r_wdata;
    logic [ADDR_W:0]  r_word_idx;
    logic             r_cpu_hold;
    logic             r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic             w_hs;
    logic [15:0]      w_len_full;
    logic [ADDR_W:0]  w_idx_inc;
    logic             w_last;
    logic             w_len_zero;
    logic             w_len_ovf;

    always_comb begin
        bus.s_ready = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (r_state == S_CSUM) bus.s_ready = 1'b1;
`endif
    end

    assign w_hs       = bus.s_valid & bus.s_ready;
    assign w_len_full = {bus.s_data, r_len[7:0]};
    assign w_idx_inc  = r_word_idx + 1'b1;
    assign w_last     = (CW'(w_idx_inc) == CW'(r_len));
    assign w_len_zero = (w_len_full == 16'd0);
    assign w_len_ovf  = (CW'(w_len_full) > MAX_WORDS);

    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = 32'({r_word_idx, 2'b00});
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = r_err;
    assign bus.word_count = r_word_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_bcnt     <= '0;
            r_wdata    <= '0;
            r_word_idx <= '0;
            r_cpu_hold <= 1'b1;
            r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_LEN0;
                        r_err      <= 1'b0;
                        r_word_idx <= '0;
                        r_cpu_hold <= 1'b1;
                        r_bcnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (w_hs) begin
                        r_len[7:0] <= bus.s_data;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_hs) begin
                        r_len <= w_len_full;
                        if (w_len_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_cpu_hold <= 1'b0;
`endif
                        end else if (w_len_ovf) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        // Little-endian assembly: first byte of a word lands in [7:0].
                        r_wdata[{r_bcnt, 3'b000} +: 8] <= bus.s_data;
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.s_data;
`endif
                        if (r_bcnt == 2'd3) r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_inc;
                    if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= S_CSUM;
`else
                        r_state    <= S_DONE;
                        r_cpu_hold <= 1'b0;
`endif
                    end else begin
                        r_state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        if (bus.s_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven load sessions plus hand-written reset, max-fill and checksum cases.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(.ADDR_W(10)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        string        name;
        logic [95:0]  bytes;
        int           n;
        bit           gap;
        bit           restart;
        int           exp_done;
        bit           exp_err;
        int           exp_wc;
        bit           exp_hold;
    } vec_t;

    vec_t        vecs [6];
    int          ntot = 0;
    int          nbad = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q  [$];
    logic [7:0]  stim_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, score writes and done pulses.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                ntot++;
                nbad++;
                $display("FAIL unexpected_write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.imem_addr, e[63:32]);
                chk("wr_data", bus.imem_wdata, e[31:0]);
            end
        end
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit restart);
        int k = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            ntot++;
            nbad++;
            $display("FAIL s_ready_timeout actual=0 required=1");
        end else begin
            tick();
        end
        if (gap) begin
            bus.s_valid = 1'b0;
            bus.start   = restart;
            tick();
            bus.start   = 1'b0;
        end
    endtask

    // Reference model: every complete little-endian payload word becomes an expected write.
    task automatic model_push(output int len, output logic [7:0] x);
        logic [31:0] w;
        len = {stim_q[1], stim_q[0]};
        x   = 8'h00;
        for (int i = 2; i < stim_q.size(); i++) x = x ^ stim_q[i];
        if (len <= 1024) begin
            for (int wi = 0; wi < len; wi++) begin
                if (2 + 4*wi + 3 < stim_q.size()) begin
                    w = {stim_q[2+4*wi+3], stim_q[2+4*wi+2], stim_q[2+4*wi+1], stim_q[2+4*wi]};
                    exp_q.push_back({32'(wi*4), w});
                end
            end
        end
    endtask

    task automatic run_session(input bit gap, input bit restart, input bit auto_csum);
        int          len;
        int          k;
        logic [7:0]  x;
        model_push(len, x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (auto_csum && len <= 1024) stim_q.push_back(x);
`else
        if (auto_csum && x === 8'hxx) $display("note: undefined payload byte");
`endif
        done_cnt  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        foreach (stim_q[i]) send_byte(stim_q[i], gap, restart);
        bus.s_valid = 1'b0;
        k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("busy_fall", bus.busy, 0);
    endtask

    task automatic post_check(input string nm, input int e_done, input bit e_err, input int e_wc,
                              input bit e_hold);
        chk({nm, "_done"}, done_cnt, e_done);
        chk({nm, "_err"}, bus.err, e_err);
        chk({nm, "_wc"}, bus.word_count, e_wc);
        chk({nm, "_hold"}, bus.cpu_hold, e_hold);
        chk({nm, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{"two_words",    96'h0000_0302_0133_0000_0013_0002, 10, 1'b0, 1'b0, 1, 1'b0, 2, 1'b0};
        vecs[1] = '{"len0",         96'h0000,                           2, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[2] = '{"overflow",     96'hFFFF,                           2, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1};
        vecs[3] = '{"one_word",     96'hDDCC_BBAA_0001,                 6, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0};
        vecs[4] = '{"len_1025",     96'h0401,                           2, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1};
        vecs[5] = '{"gaps_restart", 96'h0000_0302_0133_0000_0013_0002, 10, 1'b1, 1'b1, 1, 1'b0, 2, 1'b0};

        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #1 rst = 1'b1;
        #2;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wc", bus.word_count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            logic [95:0] tmp;
            tmp = vecs[v].bytes;
            stim_q.delete();
            for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(tmp[8*i +: 8]);
            run_session(vecs[v].gap, vecs[v].restart, 1'b1);
            post_check(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wc, vecs[v].exp_hold);
            tick();
        end

        // Exact fill of 2**ADDR_W words: last address 0xFFC, word_count 1024.
        stim_q.delete();
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h04);
        for (int i = 0; i < 4096; i++) stim_q.push_back(8'(i * 7 + 1));
        run_session(1'b0, 1'b0, 1'b1);
        post_check("max_fill", 1, 1'b0, 1024, 1'b0);
        tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Payload 13 00 00 00 33 01 02 03 XORs to 0x20.
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01, 8'h02, 8'h03, 8'h20};
        run_session(1'b0, 1'b0, 1'b0);
        post_check("csum_ok", 1, 1'b0, 2, 1'b0);
        tick();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01, 8'h02, 8'h03, 8'h24};
        run_session(1'b0, 1'b0, 1'b0);
        post_check("csum_bad", 0, 1'b1, 2, 1'b1);
        tick();
`endif

        // Async reset mid-session after 6 payload bytes: only word 0 may have been written.
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01};
        begin
            int          len;
            logic [7:0]  x;
            model_push(len, x);
        end
        done_cnt  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        foreach (stim_q[i]) send_byte(stim_q[i], 1'b0, 1'b0);
        bus.s_valid = 1'b0;
        chk("mid_busy_before_rst", bus.busy, 1);
        chk("mid_hold_before_rst", bus.cpu_hold, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hold", bus.cpu_hold, 1);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_imem_we", bus.imem_we, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_err", bus.err, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mid_idle_busy", bus.busy, 0);
        chk("mid_idle_wc", bus.word_count, 0);
        chk("mid_done", done_cnt, 0);
        chk("mid_writes_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
